// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg
// Shared types for the memory-stage controller: word and register-index
// types, FSM state encodings, the word-alignment mask and the packed
// MEM/WB latch record.
package mem_stage_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [4:0]        regbits_t;

    // FSM state encodings
    typedef logic [1:0] memstate_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // Contents of the MEM/WB pipeline latch
    typedef struct packed {
        logic     valid;
        logic     regen;
        logic     hlt;
        word_t    porto;
        word_t    dload;
        regbits_t wsel;
        logic [1:0] regsrc;
    } memwb_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Interfaces used by mem_stage_ctrl.
//   dcache_if         : data-cache request/response handshake
//                       master = memory stage, slave = cache
//                       dmemREN/dmemWEN/dmemaddr/dmemstore : requests
//                       dhit/dmemload                      : response
//   pipeline_memwb_if : MEM/WB latch outputs (wb_*)
//                       master = memory stage, slave = writeback stage
interface dcache_if #(parameter int ADDR_W = 32);
    logic              dmemREN;
    logic              dmemWEN;
    logic [ADDR_W-1:0] dmemaddr;
    logic [ADDR_W-1:0] dmemstore;
    logic              dhit;
    logic [ADDR_W-1:0] dmemload;

    modport master (output dmemREN, dmemWEN, dmemaddr, dmemstore,
                    input  dhit, dmemload);
    modport slave  (input  dmemREN, dmemWEN, dmemaddr, dmemstore,
                    output dhit, dmemload);
endinterface

interface pipeline_memwb_if #(parameter int ADDR_W = 32);
    import mem_stage_ctrl_pkg::*;

    logic              wb_valid;
    logic              wb_regen;
    logic              wb_hlt;
    logic [ADDR_W-1:0] wb_porto;
    logic [ADDR_W-1:0] wb_dload;
    regbits_t          wb_wsel;
    logic [1:0]        wb_regsrc;

    modport master (output wb_valid, wb_regen, wb_hlt, wb_porto, wb_dload,
                           wb_wsel, wb_regsrc);
    modport slave  (input  wb_valid, wb_regen, wb_hlt, wb_porto, wb_dload,
                           wb_wsel, wb_regsrc);
endinterface

// File: rtl/mem_stage_ctrl_watchdog.sv
// mem_watchdog
// Counts cycles a data request spends outstanding. start_i loads 1,
// run_i increments (saturating at TIMEOUT), clear_i returns to 0.
// expire_o is high whenever the next count equals TIMEOUT.
// Ports: CLK, RST (async, active-high), start_i, run_i, clear_i, expire_o.
module mem_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic CLK,
    input  logic RST,
    input  logic start_i,
    input  logic run_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear dominates, then start, then saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d = CW'(1);
        end else if (run_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_d == CW'(TIMEOUT));

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller: issues the data-cache request for the
// instruction in the EX/MEM latch, stalls upstream until the cache
// answers, parks load data when the pipeline is frozen, and drives the
// MEM/WB latch. Owns the sticky halt and err flags.
// Ports:
//   CLK, RST           clock, async active-high reset
//   ex_*               EX/MEM latch fields
//   advance            pipeline latches may update this cycle
//   dc (master)        data-cache handshake
//   wb (master)        MEM/WB latch outputs
//   mem_stall          freeze upstream stages
//   halt, err          sticky status
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_porto,
    input  logic [ADDR_W-1:0] ex_rdat2,
    input  regbits_t          ex_wsel,
    input  logic              ex_regen,
    input  logic [1:0]        ex_regsrc,
    input  logic              ex_hlt,
    input  logic              ex_dmemREN,
    input  logic              ex_dmemWEN,
    input  logic              advance,
    dcache_if.master          dc,
    pipeline_memwb_if.master  wb,
    output logic              mem_stall,
    output logic              halt,
    output logic              err
);

    memstate_t         state_q, state_d;
    memwb_t            wb_q, wb_d, exFields;
    word_t             holdBuf_q, holdBuf_d;
    logic              halt_q, halt_d;
    logic              err_q, err_d;
    logic              accessReq, aligned, memop, misalign, bothReq, inReq;
    logic [ADDR_W-1:0] loadData;
    logic              wdStart, wdRun, wdClear, wdExpire;

    // Decode of the latched instruction
    assign aligned   = ((ex_porto[1:0] & WORD_ALIGN_MASK) == 2'b00);
    assign accessReq = ex_valid & (ex_dmemREN | ex_dmemWEN);
    assign memop     = accessReq & aligned;
    assign misalign  = accessReq & ~aligned;
    assign bothReq   = ex_valid & ex_dmemREN & ex_dmemWEN;
    assign inReq     = (state_q == ST_IDLE) | (state_q == ST_WAIT);

    // Stores retire with zero load data; read wins over write
    assign loadData  = ex_dmemREN ? dc.dmemload : '0;

    // Cache request and stall; gated by RST so every output reads 0 in reset
    assign dc.dmemREN   = ~RST & inReq & memop & ex_dmemREN;
    assign dc.dmemWEN   = ~RST & inReq & memop & ex_dmemWEN & ~ex_dmemREN;
    assign dc.dmemaddr  = RST ? '0 : {ex_porto[ADDR_W-1:2], 2'b00};
    assign dc.dmemstore = RST ? '0 : ex_rdat2;
    assign mem_stall    = ~RST & inReq & memop & ~dc.dhit;

    // EX fields as they would enter MEM/WB; misaligned ops lose their write
    always_comb begin
        exFields        = '0;
        exFields.valid  = ex_valid;
        exFields.regen  = ex_regen & ~misalign;
        exFields.hlt    = ex_valid & ex_hlt;
        exFields.porto  = ex_porto;
        exFields.dload  = '0;
        exFields.wsel   = ex_wsel;
        exFields.regsrc = ex_regsrc;
    end

    // Next-state, MEM/WB, hold buffer and sticky flags
    always_comb begin
        state_d   = state_q;
        wb_d      = wb_q;
        holdBuf_d = holdBuf_q;
        halt_d    = halt_q;
        err_d     = err_q | wdExpire;
        wdStart   = 1'b0;
        wdRun     = 1'b0;
        wdClear   = 1'b0;

        if (inReq & (misalign | bothReq)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ex_valid & ex_hlt & advance) begin
                    wb_d    = exFields;
                    halt_d  = 1'b1;
                    state_d = ST_HALT;
                end else if (memop) begin
                    if (dc.dhit) begin
                        if (advance) begin
                            wb_d       = exFields;
                            wb_d.dload = loadData;
                        end else begin
                            holdBuf_d = loadData;
                            state_d   = ST_HOLD;
                        end
                    end else begin
                        wdStart = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else if (advance) begin
                    wb_d = exFields;
                end
            end
            ST_WAIT: begin
                // A vanished request (latch changed under us) just drops back
                if (!memop) begin
                    wdClear = 1'b1;
                    state_d = ST_IDLE;
                end else if (dc.dhit) begin
                    wdClear = 1'b1;
                    if (advance) begin
                        wb_d       = exFields;
                        wb_d.dload = loadData;
                        state_d    = ST_IDLE;
                    end else begin
                        holdBuf_d = loadData;
                        state_d   = ST_HOLD;
                    end
                end else begin
                    wdRun = 1'b1;
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    wb_d       = exFields;
                    wb_d.dload = holdBuf_q;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                halt_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            wb_q      <= '0;
            holdBuf_q <= '0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_q      <= wb_d;
            holdBuf_q <= holdBuf_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
        end
    end

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .CLK      (CLK),
        .RST      (RST),
        .start_i  (wdStart),
        .run_i    (wdRun),
        .clear_i  (wdClear),
        .expire_o (wdExpire)
    );

    assign wb.wb_valid  = wb_q.valid;
    assign wb.wb_regen  = wb_q.regen;
    assign wb.wb_hlt    = wb_q.hlt;
    assign wb.wb_porto  = wb_q.porto;
    assign wb.wb_dload  = wb_q.dload;
    assign wb.wb_wsel   = wb_q.wsel;
    assign wb.wb_regsrc = wb_q.regsrc;
    assign halt         = halt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
// Self-checking bench for mem_stage_ctrl with a short watchdog. Expected
// MEM/WB records are queued as each instruction is driven and compared
// when the stage retires it.
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;

    localparam int TIMEOUT = 4;

    logic        CLK, RST;
    logic        ex_valid, ex_regen, ex_hlt, ex_dmemREN, ex_dmemWEN, advance;
    logic [31:0] ex_porto, ex_rdat2;
    logic [4:0]  ex_wsel;
    logic [1:0]  ex_regsrc;
    logic        mem_stall, halt, err;

    int vectors     = 0;
    int miscompares = 0;
    memwb_t sbQ[$];

    dcache_if         dc();
    pipeline_memwb_if wb();

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ex_valid   (ex_valid),
        .ex_porto   (ex_porto),
        .ex_rdat2   (ex_rdat2),
        .ex_wsel    (ex_wsel),
        .ex_regen   (ex_regen),
        .ex_regsrc  (ex_regsrc),
        .ex_hlt     (ex_hlt),
        .ex_dmemREN (ex_dmemREN),
        .ex_dmemWEN (ex_dmemWEN),
        .advance    (advance),
        .dc         (dc),
        .wb         (wb),
        .mem_stall  (mem_stall),
        .halt       (halt),
        .err        (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case something wedges the sequence
    initial begin
        #100000;
        $display("[TB] FAIL globalTimeout: observed no finish, expected finish");
        $fatal(1, "[TB] bench did not complete");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [4:0] wsel, input logic regen, input logic [1:0] regsrc,
                                 input logic hlt, input logic ren, input logic wen);
        ex_valid   = v;
        ex_porto   = addr;
        ex_rdat2   = sdata;
        ex_wsel    = wsel;
        ex_regen   = regen;
        ex_regsrc  = regsrc;
        ex_hlt     = hlt;
        ex_dmemREN = ren;
        ex_dmemWEN = wen;
    endtask

    task automatic bubble();
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        advance = 1'b0;
        dc.dhit = 1'b0;
    endtask

    task automatic pushExpect(input logic regenExp, input logic [31:0] dload);
        memwb_t e;
        e.valid  = ex_valid;
        e.regen  = regenExp;
        e.hlt    = ex_valid & ex_hlt;
        e.porto  = ex_porto;
        e.dload  = dload;
        e.wsel   = ex_wsel;
        e.regsrc = ex_regsrc;
        sbQ.push_back(e);
    endtask

    task automatic checkRetire(input string tag);
        memwb_t e;
        checkOutput({tag, ".queued"}, 32'(sbQ.size()), 32'd1);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({tag, ".wb_valid"},  32'(wb.wb_valid),  32'(e.valid));
            checkOutput({tag, ".wb_regen"},  32'(wb.wb_regen),  32'(e.regen));
            checkOutput({tag, ".wb_hlt"},    32'(wb.wb_hlt),    32'(e.hlt));
            checkOutput({tag, ".wb_porto"},  wb.wb_porto,       e.porto);
            checkOutput({tag, ".wb_dload"},  wb.wb_dload,       e.dload);
            checkOutput({tag, ".wb_wsel"},   32'(wb.wb_wsel),   32'(e.wsel));
            checkOutput({tag, ".wb_regsrc"}, 32'(wb.wb_regsrc), 32'(e.regsrc));
        end
    endtask

    task automatic doReset();
        RST = 1'b1;
        bubble();
        tick();
        checkOutput("rst.halt", 32'(halt), 32'd0);
        checkOutput("rst.err", 32'(err), 32'd0);
        checkOutput("rst.wb_valid", 32'(wb.wb_valid), 32'd0);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        dc.dmemload = 32'h0;
        bubble();
        tick();
        tick();

        // Reset state, with a load sitting on the EX fields
        applyStimulus(1'b1, 32'h40, 32'h99, 5'd1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("reset.dmemREN", 32'(dc.dmemREN), 32'd0);
        checkOutput("reset.dmemWEN", 32'(dc.dmemWEN), 32'd0);
        checkOutput("reset.stall", 32'(mem_stall), 32'd0);
        checkOutput("reset.dmemaddr", dc.dmemaddr, 32'd0);
        checkOutput("reset.halt", 32'(halt), 32'd0);
        checkOutput("reset.err", 32'(err), 32'd0);
        checkOutput("reset.wb_valid", 32'(wb.wb_valid), 32'd0);
        checkOutput("reset.wb_dload", wb.wb_dload, 32'd0);
        bubble();
        tick();
        RST = 1'b0;

        // Load hit with advance: retires with zero extra cycles
        applyStimulus(1'b1, 32'h40, 32'h1234, 5'd5, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        dc.dhit = 1'b1;
        dc.dmemload = 32'hDEAD_BEEF;
        advance = 1'b1;
        #1;
        checkOutput("ldHit.dmemREN", 32'(dc.dmemREN), 32'd1);
        checkOutput("ldHit.dmemWEN", 32'(dc.dmemWEN), 32'd0);
        checkOutput("ldHit.stall", 32'(mem_stall), 32'd0);
        checkOutput("ldHit.dmemaddr", dc.dmemaddr, 32'h40);
        pushExpect(1'b1, 32'hDEAD_BEEF);
        tick();
        checkRetire("ldHit");
        bubble();

        // Store miss for three cycles, advance held high throughout
        applyStimulus(1'b1, 32'h80, 32'hCAFE_F00D, 5'd7, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        advance = 1'b1;
        pushExpect(1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("stMiss%0d.dmemWEN", i), 32'(dc.dmemWEN), 32'd1);
            checkOutput($sformatf("stMiss%0d.dmemREN", i), 32'(dc.dmemREN), 32'd0);
            checkOutput($sformatf("stMiss%0d.stall", i), 32'(mem_stall), 32'd1);
            checkOutput($sformatf("stMiss%0d.dmemstore", i), dc.dmemstore, 32'hCAFE_F00D);
            tick();
            checkOutput($sformatf("stMiss%0d.wbHeld", i), wb.wb_porto, 32'h40);
        end
        dc.dhit = 1'b1;
        #1;
        checkOutput("stDone.stall", 32'(mem_stall), 32'd0);
        checkOutput("stDone.dmemWEN", 32'(dc.dmemWEN), 32'd1);
        tick();
        checkRetire("stMiss");
        checkOutput("stMiss.err", 32'(err), 32'd0);
        bubble();

        // Load hit while frozen: data parked in the hold buffer
        applyStimulus(1'b1, 32'h100, 32'h0, 5'd9, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        dc.dhit = 1'b1;
        dc.dmemload = 32'h1122_3344;
        advance = 1'b0;
        #1;
        checkOutput("hold.dmemREN0", 32'(dc.dmemREN), 32'd1);
        checkOutput("hold.stall0", 32'(mem_stall), 32'd0);
        tick();
        checkOutput("hold.dmemREN1", 32'(dc.dmemREN), 32'd0);
        checkOutput("hold.stall1", 32'(mem_stall), 32'd0);
        dc.dmemload = 32'hBAD0_BAD0;
        tick();
        checkOutput("hold.wbHeld", wb.wb_porto, 32'h80);
        advance = 1'b1;
        pushExpect(1'b1, 32'h1122_3344);
        tick();
        checkRetire("hold");
        checkOutput("hold.err", 32'(err), 32'd0);
        bubble();

        // Misaligned load: no request, err, register write dropped
        applyStimulus(1'b1, 32'h42, 32'h0, 5'd3, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        dc.dhit = 1'b1;
        dc.dmemload = 32'h55;
        advance = 1'b1;
        #1;
        checkOutput("misal.dmemREN", 32'(dc.dmemREN), 32'd0);
        checkOutput("misal.stall", 32'(mem_stall), 32'd0);
        checkOutput("misal.dmemaddr", dc.dmemaddr, 32'h40);
        pushExpect(1'b0, 32'h0);
        tick();
        checkRetire("misal");
        checkOutput("misal.err", 32'(err), 32'd1);
        bubble();

        // REN and WEN together: read wins, err set
        doReset();
        applyStimulus(1'b1, 32'h300, 32'h77, 5'd4, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1);
        dc.dhit = 1'b1;
        dc.dmemload = 32'hA5A5_A5A5;
        advance = 1'b1;
        #1;
        checkOutput("both.dmemREN", 32'(dc.dmemREN), 32'd1);
        checkOutput("both.dmemWEN", 32'(dc.dmemWEN), 32'd0);
        pushExpect(1'b1, 32'hA5A5_A5A5);
        tick();
        checkRetire("both");
        checkOutput("both.err", 32'(err), 32'd1);
        bubble();

        // Watchdog: err rises on the TIMEOUT-th WAIT cycle, then reset mid-WAIT
        doReset();
        applyStimulus(1'b1, 32'h200, 32'h0, 5'd2, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        dc.dhit = 1'b0;
        advance = 1'b1;
        #1;
        checkOutput("wd.stall0", 32'(mem_stall), 32'd1);
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            checkOutput($sformatf("wd.err%0d", c), 32'(err), (c >= TIMEOUT) ? 32'd1 : 32'd0);
            checkOutput($sformatf("wd.dmemREN%0d", c), 32'(dc.dmemREN), 32'd1);
        end
        tick();
        checkOutput("wd.errSat", 32'(err), 32'd1);
        checkOutput("wd.stallSat", 32'(mem_stall), 32'd1);
        RST = 1'b1;
        #1;
        checkOutput("wdRst.dmemREN", 32'(dc.dmemREN), 32'd0);
        checkOutput("wdRst.stall", 32'(mem_stall), 32'd0);
        checkOutput("wdRst.err", 32'(err), 32'd0);
        checkOutput("wdRst.dmemaddr", dc.dmemaddr, 32'd0);
        checkOutput("wdRst.wb_valid", 32'(wb.wb_valid), 32'd0);
        bubble();
        tick();
        RST = 1'b0;
        tick();
        checkOutput("wdPost.dmemREN", 32'(dc.dmemREN), 32'd0);
        checkOutput("wdPost.err", 32'(err), 32'd0);

        // Halt: sticky, blocks later requests until reset
        applyStimulus(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        advance = 1'b1;
        pushExpect(1'b0, 32'h0);
        tick();
        checkRetire("halt");
        checkOutput("halt.halt", 32'(halt), 32'd1);
        applyStimulus(1'b1, 32'h40, 32'h0, 5'd6, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        dc.dhit = 1'b1;
        dc.dmemload = 32'h1357_9BDF;
        #1;
        checkOutput("halted.dmemREN", 32'(dc.dmemREN), 32'd0);
        checkOutput("halted.stall", 32'(mem_stall), 32'd0);
        tick();
        checkOutput("halted.halt", 32'(halt), 32'd1);
        checkOutput("halted.wb_hlt", 32'(wb.wb_hlt), 32'd1);
        checkOutput("halted.wb_porto", wb.wb_porto, 32'h0);
        RST = 1'b1;
        bubble();
        #1;
        checkOutput("haltRst.halt", 32'(halt), 32'd0);
        checkOutput("haltRst.wb_hlt", 32'(wb.wb_hlt), 32'd0);
        tick();
        RST = 1'b0;

        checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
